data_mem_be: RTL
================

# data_mem_be

Parametrised single-port data memory for the CPU load/store path, with byte/halfword/word access, byte-lane write enables, and sign or zero extension on loads. It adds a valid/ready request and response handshake, and detects misaligned and out-of-range accesses. Each faulting access is reported on the response and recorded in a sticky fault record for the exception logic. It sits between the MEM stage and the inferred block RAM, and replaces the fixed word-only data memory.

## Interface
Parameters:
- ADDR_WIDTH, 14, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words, mapped at byte address 0.
- MEM_INIT, "", hex init file loaded with $readmemh; empty string means no init.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as a fault.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- address  in  32  byte address.
- writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  load response valid.
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
- readData  out  32  formatted load data.
- rsp_error  out  1  response belongs to a faulting load; readData = 0.
- fault  out  1  sticky fault flag.
- fault_addr  out  32  address of the first fault since the last clear.
- fault_clear  in  1  clears fault and fault_addr.

## Operation
- Pipeline with one response stage; req_ready = !rsp_valid || rsp_ready.
- Fault conditions (any one is sufficient):
  - req_size = 11;
  - half access with address[0] = 1;
  - word access with address[1:0] != 0;
  - address[31:ADDR_WIDTH+2] != 0.
- Accepted store, no fault: write the word at address[ADDR_WIDTH+1:2] on the acceptance edge.
  - Byte: lane address[1:0] gets writeData[7:0].
  - Half: lanes {address[1],0} and {address[1],1} get writeData[15:0].
  - Word: all four lanes.
  - Unselected lanes are unchanged.
  - Stores generate no response.
- Accepted faulting store: memory is untouched, no response, fault record updated.
- Accepted load: read the word on the acceptance edge; rsp_valid = 1 from the next cycle.
  - readData is extracted from the lane selected by the captured address[1:0] and size.
  - Extended per the captured req_unsigned.
- Accepted faulting load: memory is not read; rsp_valid = 1 with rsp_error = 1 and readData = 0.
- Response hold: while rsp_valid && !rsp_ready, readData, rsp_error and the RAM output are held, and req_ready = 0.
- Fault record:
  - On the first fault while fault = 0, set fault = 1 and capture fault_addr.
  - Later faults do not overwrite fault_addr.
  - fault_clear in the same cycle as a new fault: the new fault wins (fault = 1, fault_addr = new address).
- Response register state: EMPTY and FULL.
  - EMPTY -> FULL on load accept.
  - FULL -> EMPTY on rsp_ready with no new load.
  - FULL -> FULL on rsp_ready plus a new load accepted in the same cycle.
- Read-during-write cannot occur (single port, one request per cycle). A load accepted the cycle after a store to the same word returns the stored data.

## Timing
- Reset values:
  - req_ready = 0 during reset, 1 on the first cycle after reset;
  - rsp_valid, rsp_error and fault = 0;
  - readData and fault_addr = 0.
- Memory contents are not affected by reset.
- Reset mid-operation: a pending response is dropped, and a store presented in the reset cycle is not performed.
- Load latency is 1 cycle (accept at edge N, rsp_valid high after edge N).
- Throughput is one request per cycle when rsp_ready is held high.
- Store effect is visible to a load accepted at edge N+1 or later.
- Fault and fault_addr update on the acceptance edge of the faulting request.

## Test plan
- Store word 0x8899AABB at 0x10, then load byte at 0x11 signed -> readData 0xFFFFFFAA; unsigned -> 0x000000AA; half at 0x12 signed -> 0xFFFF8899.
- Store byte 0x5A at 0x21 over word 0x11223344 at 0x20, then load word -> 0x11225A44; store half 0xBEEF at 0x22 -> 0xBEEF5A44.
- Back-to-back loads at 0x0, 0x4, 0x8 with rsp_ready low for 3 cycles after the first response:
  - req_ready = 0 while stalled;
  - first readData held stable;
  - all three responses delivered in order, none lost.
- Fault cases:
  - Load word at 0x6 -> rsp_error = 1, readData = 0, fault = 1, fault_addr = 0x6.
  - Then store half at 0x9 -> memory unchanged, fault_addr remains 0x6.
  - fault_clear together with a load at 0x10000 (ADDR_WIDTH = 14) -> fault = 1, fault_addr = 0x10000.
- Assert reset in the cycle after a load is accepted -> rsp_valid = 0 after the edge. A store presented during reset leaves the target word unchanged on readback.
- req_size = 11 store at 0x0 -> no write, fault = 1; load word at 0x0 afterwards returns the prior contents.

Source files
------------

// File: rtl/data_mem_be.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_be
// Description : Single-port CPU data memory with byte/half/word access,
//               byte-lane write enables, sign/zero-extending loads, a
//               valid/ready request/response handshake and a sticky fault
//               record for misaligned, illegal-size and out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_be #(
    parameter int    ADDR_WIDTH = 14,
    parameter string MEM_INIT   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] readData,
    output logic        rsp_error,
    output logic        fault,
    output logic [31:0] fault_addr,
    input  logic        fault_clear
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [31:0] mem [0:DEPTH-1];

    logic [0:0]            state_q, state_d;
    logic [31:0]           ram_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  err_q;
    logic                  fault_q;
    logic [31:0]           fault_addr_q;

    logic                  w_accept;
    logic                  w_fault;
    logic                  w_out_of_range;
    logic                  w_store_en;
    logic                  w_load_acc;
    logic                  w_load_rd;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_lane_byte;
    logic [15:0]           w_lane_half;
    logic [31:0]           w_fmt;

    // Handshake: a new request fits whenever the response slot is free or
    // being drained this cycle; nothing is accepted while in reset.
    assign req_ready      = !reset && ((state_q == ST_EMPTY) || rsp_ready);
    assign w_accept       = req_valid && req_ready;
    assign w_idx          = address[ADDR_WIDTH+1:2];
    assign w_out_of_range = (address >> (ADDR_WIDTH + 2)) != 32'd0;

    assign w_fault = (req_size == 2'b11)
                  || ((req_size == 2'b01) && address[0])
                  || ((req_size == 2'b10) && (address[1:0] != 2'b00))
                  || w_out_of_range;

    assign w_store_en = w_accept && req_write && !w_fault;
    assign w_load_acc = w_accept && !req_write;
    assign w_load_rd  = w_load_acc && !w_fault;

    // Byte-lane enables and lane-replicated store data from size and offset.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writeData;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << address[1:0];
                w_wdata = {4{writeData[7:0]}};
            end
            2'b01: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{writeData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = writeData;
            end
        endcase
    end

    // Byte-enabled RAM write on the acceptance edge of a clean store.
    always_ff @(posedge clock) begin
        if (w_store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
        end
    end

    // RAM read port; the output register holds while a response is stalled.
    always_ff @(posedge clock) begin
        if (w_load_rd) begin
            ram_q <= mem[w_idx];
        end
    end

    // Response slot occupancy: filled by any load, drained by rsp_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_load_acc) state_d = ST_FULL;
            ST_FULL: begin
                if (w_load_acc)     state_d = ST_FULL;
                else if (rsp_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Response state and captured load attributes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_load_acc) begin
                off_q  <= address[1:0];
                size_q <= req_size;
                uns_q  <= req_unsigned;
                err_q  <= w_fault;
            end
        end
    end

    // Load data formatting: lane select then sign or zero extension.
    always_comb begin
        w_lane_byte = ram_q[{off_q, 3'b000} +: 8];
        w_lane_half = off_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (size_q)
            2'b00:   w_fmt = {{24{!uns_q && w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_fmt = {{16{!uns_q && w_lane_half[15]}}, w_lane_half};
            default: w_fmt = ram_q;
        endcase
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_error = rsp_valid && err_q;
    assign readData  = (rsp_valid && !err_q) ? w_fmt : 32'd0;

    // Sticky fault record: first fault wins; a new fault beats a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else if (w_accept && w_fault && (!fault_q || fault_clear)) begin
            fault_q      <= 1'b1;
            fault_addr_q <= address;
        end else if (fault_clear) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule
`default_nettype wire
